// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, funct codes and default width for the mult/div sequencer.
package muldiv_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV = 6'h1A;
    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;
endpackage

// File: rtl/muldiv_seq_div_step.sv
// div_step: one combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH:0]   divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q
);
    logic [WIDTH:0] shifted;
    logic [WIDTH+1:0] diff;
    assign shifted = {rem, dividend_bit};
    assign diff = {1'b0, shifted} - {1'b0, divisor};
    assign q = ~diff[WIDTH+1];
    assign rem_next = q ? diff[WIDTH:0] : shifted;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle signed Booth multiply / restoring divide committing to HI/LO.
import muldiv_pkg::*;

module muldiv_seq #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    state_t state, state_next;
    logic [2*WIDTH:0] acc, mult_next, div_next, acc_next;
    logic [WIDTH:0] opb, a_sum, rem_next;
    logic [WIDTH-1:0] a_abs, b_abs, div_lo, div_hi;
    logic [CW-1:0] cnt;
    logic bb, q_bit, q_neg, r_neg, last, go_mult, go_div, dz;

    assign busy = (state == MULT) || (state == DIV);
    assign last = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        go_mult = 1'b0;
        go_div = 1'b0;
        dz = 1'b0;
        case (state)
            IDLE: begin
                go_mult = start_mult;
                go_div = !start_mult && start_div && (b != '0);
                dz = !start_mult && start_div && (b == '0);
                state_next = go_mult ? MULT : go_div ? DIV : IDLE;
            end
            MULT, DIV: state_next = last ? FINISH : state;
            default: state_next = IDLE;
        endcase
    end

    // Booth pair {q0, q-1}: 10 subtracts the multiplicand, 01 adds it
    assign a_sum = (acc[0] && !bb) ? acc[2*WIDTH:WIDTH] - opb :
                   (!acc[0] && bb) ? acc[2*WIDTH:WIDTH] + opb : acc[2*WIDTH:WIDTH];
    assign mult_next = {a_sum[WIDTH], a_sum, acc[WIDTH-1:1]};

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem(acc[2*WIDTH-1:WIDTH]),
        .dividend_bit(acc[WIDTH-1]),
        .divisor(opb),
        .rem_next(rem_next),
        .q(q_bit)
    );
    assign div_next = {rem_next, acc[WIDTH-2:0], q_bit};
    assign acc_next = (state == MULT) ? mult_next : div_next;

    assign a_abs = a[WIDTH-1] ? -a : a;
    assign b_abs = b[WIDTH-1] ? -b : b;
    assign div_lo = q_neg ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign div_hi = r_neg ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
            opb <= '0;
            bb <= 1'b0;
            cnt <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            hi <= '0;
            lo <= '0;
            done <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= dz || (busy && last);
            div_zero <= dz;
            if (go_mult) begin
                acc <= {{(WIDTH+1){1'b0}}, b};
                opb <= {a[WIDTH-1], a};
                bb <= 1'b0;
                cnt <= '0;
            end else if (go_div) begin
                acc <= {{(WIDTH+1){1'b0}}, a_abs};
                opb <= {1'b0, b_abs};
                q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
                r_neg <= a[WIDTH-1];
                cnt <= '0;
            end else if (busy) begin
                acc <= acc_next;
                bb <= acc[0];
                cnt <= last ? '0 : cnt + CW'(1);
                // HI/LO change only here, so intermediate values never show
                if (last) {hi, lo} <= (state == MULT) ? mult_next[2*WIDTH-1:0] : {div_hi, div_lo};
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random scoreboard checks of muldiv_seq latency, results and control pulses.
module tb_muldiv_seq;
    logic clk, reset, start_mult, start_div, busy, done, div_zero;
    logic [31:0] a, b, hi, lo;
    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb[$];
    logic [63:0] last_commit = 64'd0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic m, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        sx = $signed(x);
        sy = $signed(y);
        p = sx * sy;
        q = sx / sy;
        r = sx % sy;
        return m ? p : {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input string tag, input logic sm, input logic sd,
                          input logic [31:0] x, input logic [31:0] y, input int inject);
        int k;
        int busy_cnt;
        logic seen;
        logic [63:0] exp;
        @(negedge clk);
        start_mult = sm;
        start_div = sd;
        a = x;
        b = y;
        sb.push_back(model(sm, x, y));
        @(negedge clk);
        start_mult = 1'b0;
        start_div = 1'b0;
        busy_cnt = 0;
        seen = 1'b0;
        for (k = 1; k <= 40 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            else start_div = (k == inject);
        end
        start_div = 1'b0;
        check({tag, "_latency"}, 64'(k - 1), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        exp = sb.pop_front();
        if (seen) last_commit = exp;
        check({tag, "_hilo"}, {hi, lo}, exp);
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b0;
        start_mult = 1'b0;
        start_div = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset_ctl", {61'd0, busy, done, div_zero}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;

        run_op("mult_7x-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("mult_m1xm1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mult_minxmin", 1, 0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_100_7", 0, 1, 32'd100, 32'd7, 0);

        // divide by zero: one-cycle flag pulse, HI/LO keep the last committed result
        @(negedge clk);
        start_div = 1'b1;
        a = 32'd55;
        b = 32'd0;
        sb.push_back(last_commit);
        @(negedge clk);
        start_div = 1'b0;
        check("dz_flags", {61'd0, busy, done, div_zero}, 64'd3);
        @(negedge clk);
        check("dz_clear", {61'd0, busy, done, div_zero}, 64'd0);
        check("dz_hilo", {hi, lo}, sb.pop_front());

        run_op("arb_both", 1, 1, 32'd6, 32'd3, 0);
        run_op("ignore_div", 1, 0, 32'd12345, 32'hFFFF_0001, 5);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op("rand_mult", 1, 0, ra, rb, 0);
            rb = (i[0]) ? ($urandom & 32'h0000_00FF) : $urandom;
            if (rb == 0) rb = 32'd3;
            run_op("rand_div", 0, 1, ra, rb, 0);
        end

        // reset mid-operation aborts without a done pulse and clears HI/LO
        @(negedge clk);
        start_mult = 1'b1;
        a = 32'd9;
        b = 32'd9;
        @(negedge clk);
        start_mult = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_ctl", {62'd0, busy, done}, 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_no_done", {62'd0, busy, done}, 64'd0);
        run_op("after_reset", 1, 0, 32'hFFFF_FF00, 32'd1000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
